if_branch_predictor: RTL and testbench

Direct-mapped branch predictor in the IF stage: 2-bit saturating counters plus a tagged branch target buffer. Each cycle it turns the fetch PC into `jump_prediction` and `addr_prediction`, which travel down the pipeline to the EX-stage jump handler. It is trained from EX with the resolved outcome and target of every jump or branch that is not flushed. Lookup is combinational; training is registered.

---
 rtl/if_branch_predictor.sv | 91 +++++++++
 tb/tb_if_branch_predictor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/if_branch_predictor.sv
// IF-stage direct-mapped branch predictor: 2-bit saturating counters with a tagged BTB.
// Lookup is combinational on pc; training from EX is written on the clock edge.
module if_branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        jump_prediction,
  output logic [31:0] addr_prediction,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic                  rd_hit, wr_hit;

  logic        wr_en_d;
  logic [1:0]  wr_ctr_d;
  logic [31:0] wr_target_d;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign rd_idx = pc[INDEX_BITS+1:2];
  assign rd_tag = pc[31:INDEX_BITS+2];
  assign wr_idx = update_pc[INDEX_BITS+1:2];
  assign wr_tag = update_pc[31:INDEX_BITS+2];

  // Lookup sees pre-update contents; there is deliberately no write-to-read bypass.
  assign rd_hit          = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign jump_prediction = rd_hit && ctr_q[rd_idx][1];
  assign addr_prediction = jump_prediction ? target_q[rd_idx] : pc + 32'd4;

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    wr_en_d     = 1'b0;
    wr_ctr_d    = ctr_q[wr_idx];
    wr_target_d = target_q[wr_idx];
    if (update_valid) begin
      if (wr_hit) begin
        wr_en_d = 1'b1;
        if (update_taken) begin
          wr_ctr_d    = ctr_inc(ctr_q[wr_idx]);
          wr_target_d = update_target;
        end else begin
          wr_ctr_d = ctr_dec(ctr_q[wr_idx]);
        end
      end else if (update_taken) begin
        // Taken miss evicts whatever lives at this index; not-taken misses never allocate.
        wr_en_d     = 1'b1;
        wr_ctr_d    = 2'b10;
        wr_target_d = update_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      ctr_q[wr_idx]    <= wr_ctr_d;
      target_q[wr_idx] <= wr_target_d;
    end
  end

endmodule

// File: tb/tb_if_branch_predictor.sv
// Bench for if_branch_predictor: directed vector table followed by randomized
// traffic checked against an array-based reference model.
module tb_if_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        jump_prediction;
  logic [31:0] addr_prediction;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  int vectors = 0;
  int miscompares = 0;

  if_branch_predictor #(.INDEX_BITS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .jump_prediction (jump_prediction),
    .addr_prediction (addr_prediction),
    .update_valid    (update_valid),
    .update_pc       (update_pc),
    .update_taken    (update_taken),
    .update_target   (update_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [31:0] p;
    logic        uv;
    logic [31:0] up;
    logic        ut;
    logic [31:0] utg;
    logic        chk;
    logic        ejp;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [31:0] p, input logic uv,
                              input logic [31:0] up, input logic ut, input logic [31:0] utg,
                              input logic chk, input logic ejp, input logic [31:0] ea);
    vec_t v;
    v.r = r; v.p = p; v.uv = uv; v.up = up; v.ut = ut; v.utg = utg;
    v.chk = chk; v.ejp = ejp; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string nm, input logic ejp, input logic [31:0] ea);
    vectors++;
    if (jump_prediction !== ejp || addr_prediction !== ea) begin
      miscompares++;
      $display("FAIL %s: pc=%h got jump=%0b addr=%h, expected jump=%0b addr=%h",
               nm, pc, jump_prediction, addr_prediction, ejp, ea);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic uv,
                       input logic [31:0] up, input logic ut, input logic [31:0] utg);
    rst = r; pc = p; update_valid = uv; update_pc = up;
    update_taken = ut; update_target = utg;
  endtask

  // Reference model: 16 entries indexed by word address modulo 16.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic int unsigned m_tg(input logic [31:0] a);
    return a / 64;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 32'h0;
    end
  endtask

  task automatic m_predict(input logic [31:0] p, output logic ejp, output logic [31:0] ea);
    int i;
    i = m_idx(p);
    ejp = m_valid[i] && (m_tag[i] == m_tg(p)) && (m_ctr[i] >= 2);
    ea  = ejp ? m_tgt[i] : p + 32'd4;
  endtask

  task automatic m_train(input logic [31:0] up, input logic ut, input logic [31:0] utg);
    int i;
    i = m_idx(up);
    if (m_valid[i] && m_tag[i] == m_tg(up)) begin
      if (ut) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = utg;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (ut) begin
      m_valid[i] = 1; m_tag[i] = m_tg(up); m_ctr[i] = 2; m_tgt[i] = utg;
    end
  endtask

  logic [31:0] pool [8];

  initial begin
    logic        ejp;
    logic [31:0] ea;
    logic [31:0] p, up, utg;
    logic        r, uv, ut;

    drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Directed vectors: outputs are checked before the edge that applies the update.
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104));
    tbl.push_back(mk(0, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 1, 0, 32'h104));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 1, 1, 32'h200));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 1, 32'h200));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 0, 32'h104));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 1, 0, 32'h104));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 1, 0, 32'h104));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h300, 1, 1, 32'h200));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h300, 1, 1, 32'h300));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h300, 1, 1, 32'h300));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 1, 32'h300));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 1, 1, 32'h300));
    tbl.push_back(mk(0, 32'h140, 0, 0, 0, 0, 1, 0, 32'h144));
    tbl.push_back(mk(0, 32'h140, 1, 32'h140, 0, 32'h0, 1, 0, 32'h144));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 1, 1, 32'h300));
    tbl.push_back(mk(0, 32'h140, 1, 32'h140, 1, 32'h400, 1, 0, 32'h144));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104));
    tbl.push_back(mk(0, 32'h140, 0, 0, 0, 0, 1, 1, 32'h400));
    tbl.push_back(mk(0, 32'h142, 0, 0, 0, 0, 1, 1, 32'h400));
    tbl.push_back(mk(0, 32'h180, 1, 32'h180, 1, 32'h500, 1, 0, 32'h184));
    tbl.push_back(mk(0, 32'h184, 1, 32'h184, 1, 32'h600, 1, 0, 32'h188));
    tbl.push_back(mk(0, 32'h180, 0, 0, 0, 0, 1, 1, 32'h500));
    // Reset with a simultaneous update: outputs still follow the table this cycle.
    tbl.push_back(mk(1, 32'h184, 1, 32'h180, 1, 32'h700, 1, 1, 32'h600));
    tbl.push_back(mk(0, 32'h180, 0, 0, 0, 0, 1, 0, 32'h184));
    tbl.push_back(mk(0, 32'h184, 0, 0, 0, 0, 1, 0, 32'h188));
    tbl.push_back(mk(0, 32'h140, 0, 0, 0, 0, 1, 0, 32'h144));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104));

    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].p, tbl[k].uv, tbl[k].up, tbl[k].ut, tbl[k].utg);
      #1;
      if (tbl[k].chk) check($sformatf("dir%0d", k), tbl[k].ejp, tbl[k].ea);
      @(posedge clk);
      #1;
    end

    // Randomized traffic; the pool mixes aliasing PCs at index 0 with other indices.
    pool[0] = 32'h100;      pool[1] = 32'h140;  pool[2] = 32'h180;  pool[3] = 32'h1C0;
    pool[4] = 32'h104;      pool[5] = 32'h2008; pool[6] = 32'hFFFFFFFC; pool[7] = 32'h3C;

    drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 99) < 2);
      p   = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      uv  = ($urandom_range(0, 99) < 70);
      up  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      ut  = ($urandom_range(0, 99) < 60);
      utg = {$urandom_range(0, 15), 2'b00} + 32'h1000;
      drive(r, p, uv, up, ut, utg);
      #1;
      m_predict(p, ejp, ea);
      check($sformatf("rnd%0d", k), ejp, ea);
      @(posedge clk);
      if (r) m_reset();
      else if (uv) m_train(up, ut, utg);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
